// File: rtl/aes_alg_arbiter.sv
// rtl/aes_alg_arbiter.sv - two-requester round-robin front end for a shared AES core
module aes_alg_arbiter #(
    parameter int AES_BLK_BITS = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_expanded,
    input  logic                    req0_start,
    input  logic [AES_BLK_BITS-1:0] req0_in_blk,
    output logic                    req0_busy,
    output logic                    req0_done,
    output logic [AES_BLK_BITS-1:0] req0_out_blk,
    input  logic                    req1_start,
    input  logic [AES_BLK_BITS-1:0] req1_in_blk,
    output logic                    req1_busy,
    output logic                    req1_done,
    output logic [AES_BLK_BITS-1:0] req1_out_blk,
    output logic                    aes_alg_start,
    output logic [AES_BLK_BITS-1:0] aes_alg_in_blk,
    input  logic                    aes_alg_done,
    input  logic [AES_BLK_BITS-1:0] aes_alg_out_blk,
    output logic                    grant,
    output logic                    err_overrun
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              busy_q, busy_d;
    logic [1:0]              done_q, done_d;
    logic [AES_BLK_BITS-1:0] slot0_q, slot0_d;
    logic [AES_BLK_BITS-1:0] slot1_q, slot1_d;
    logic [AES_BLK_BITS-1:0] in_blk_q, in_blk_d;
    logic [AES_BLK_BITS-1:0] out0_q, out0_d;
    logic [AES_BLK_BITS-1:0] out1_q, out1_d;
    logic                    start_q, start_d;
    logic                    grant_q, grant_d;
    logic                    last_q, last_d;
    logic                    last_vld_q, last_vld_d;
    logic                    err_q, err_d;
    logic                    win;

    // Requester 1 wins only when it alone is pending, or both are and 0 was served last.
    assign win = (busy_q == 2'b10) ||
                 ((busy_q == 2'b11) && last_vld_q && !last_q);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 2'b00;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        in_blk_d   = in_blk_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
        start_d    = 1'b0;
        grant_d    = grant_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        err_d      = err_q;

        if (req0_start) begin
            if (busy_q[0]) begin
                err_d = 1'b1;
            end else begin
                busy_d[0] = 1'b1;
                slot0_d   = req0_in_blk;
            end
        end
        if (req1_start) begin
            if (busy_q[1]) begin
                err_d = 1'b1;
            end else begin
                busy_d[1] = 1'b1;
                slot1_d   = req1_in_blk;
            end
        end

        // In IDLE every busy slot is still unissued, so busy doubles as pending.
        case (state_q)
            IDLE: begin
                if (key_expanded && (busy_q != 2'b00)) begin
                    grant_d  = win;
                    in_blk_d = win ? slot1_q : slot0_q;
                    start_d  = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (aes_alg_done) begin
                    if (grant_q) begin
                        out1_d    = aes_alg_out_blk;
                        done_d[1] = 1'b1;
                        busy_d[1] = 1'b0;
                    end else begin
                        out0_d    = aes_alg_out_blk;
                        done_d[0] = 1'b1;
                        busy_d[0] = 1'b0;
                    end
                    last_d     = grant_q;
                    last_vld_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= '0;
            done_q     <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            in_blk_q   <= '0;
            out0_q     <= '0;
            out1_q     <= '0;
            start_q    <= 1'b0;
            grant_q    <= 1'b0;
            last_q     <= 1'b0;
            last_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            in_blk_q   <= in_blk_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            start_q    <= start_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            err_q      <= err_d;
        end
    end

    assign req0_busy      = busy_q[0];
    assign req1_busy      = busy_q[1];
    assign req0_done      = done_q[0];
    assign req1_done      = done_q[1];
    assign req0_out_blk   = out0_q;
    assign req1_out_blk   = out1_q;
    assign aes_alg_start  = start_q;
    assign aes_alg_in_blk = in_blk_q;
    assign grant          = grant_q;
    assign err_overrun    = err_q;

endmodule
